// File: rtl/compute_core3.sv
// Saber decryption helper: BS2POLVECp (op 9) and UNPACK (op 11) over a private
// 1024x64 data RAM that is loaded and read back through an external port.
module compute_core3 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [8:0]  address_ext,
  input  logic [63:0] dina_ext,
  input  logic        wea_ext,
  output logic [63:0] douta_ext,
  input  logic [34:0] command_in,
  input  logic        command_we0,
  input  logic        command_we1,
  output logic        done_shake,
  output logic        done_vmul,
  output logic        done_addround,
  output logic        done_addpack,
  output logic        done_bs2polvecp,
  output logic        done_unpack
);

  // state  | meaning
  // IDLE   | waiting for opcode 9 or 11; external writes allowed
  // RUN9   | BS2POLVECp: stream 10-bit coefficients into 16-bit lanes
  // RUN11  | UNPACK: round 4-bit scales against v lanes into message bits
  // DONE   | done flag high until the controller changes the opcode
  localparam int         RAM_DEPTH = 1024;
  localparam logic [9:0] H2        = 10'd228;

  typedef enum logic [1:0] {S_IDLE, S_RUN9, S_RUN11, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [63:0] mem [RAM_DEPTH];
  logic [34:0] cmd_q;
  logic [4:0]  opcode;
  logic [9:0]  base_dst, base_a, base_b;
  logic        fin9_q;

  logic [103:0] buf_q;
  logic [6:0]   bits_q;
  logic [6:0]   ld_q;
  logic [7:0]   wr_q;
  logic [5:0]   idx_q;
  logic [63:0]  acc_q, acc_nxt;

  logic [9:0]  rd_a_addr, rd_b_addr;
  logic [63:0] rd_a, rd_b, nib_word;
  logic [3:0]  m_bits;
  logic        emit9;
  logic        core_we;
  logic [9:0]  core_addr;
  logic [63:0] core_data;
  logic        ext_ok;
  logic        unused_we1;

  assign unused_we1 = command_we1;
  assign opcode     = cmd_q[4:0];

  assign done_shake      = 1'b0;
  assign done_vmul       = 1'b0;
  assign done_addround   = 1'b0;
  assign done_addpack    = 1'b0;
  assign done_bs2polvecp = (state_q == S_DONE) &&  fin9_q;
  assign done_unpack     = (state_q == S_DONE) && !fin9_q;

  assign ext_ok = (state_q == S_IDLE) || (state_q == S_DONE);
  assign emit9  = (bits_q >= 7'd40);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cmd_q <= '0;
    else if (command_we0) cmd_q <= command_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (opcode == 5'd9) state_d = S_RUN9;
               else if (opcode == 5'd11) state_d = S_RUN11;
      S_RUN9:  if (emit9 && wr_q == 8'd191) state_d = S_DONE;
      S_RUN11: if (idx_q == 6'd63) state_d = S_DONE;
      S_DONE:  if (opcode != (fin9_q ? 5'd9 : 5'd11)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Core read ports: srcA (packed stream / scales) and srcB (v lanes).
  always_comb begin
    rd_a_addr = (state_q == S_RUN9) ? base_a + {3'b000, ld_q}
                                    : base_a + {6'b000000, idx_q[5:2]};
    rd_b_addr = base_b + {4'b0000, idx_q};
  end
  assign rd_a = mem[rd_a_addr];
  assign rd_b = mem[rd_b_addr];

  // Four message bits per cycle; nibble group selected by idx[1:0].
  assign nib_word = rd_a >> {idx_q[1:0], 4'b0000};
  always_comb begin
    logic [9:0] t;
    m_bits = '0;
    for (int k = 0; k < 4; k++) begin
      t = rd_b[16*k +: 10] + H2 - {nib_word[4*k +: 4], 6'b000000};
      m_bits[k] = t[9];
    end
    acc_nxt = (acc_q & ~(64'hF << {idx_q[3:0], 2'b00}))
            | ({60'd0, m_bits} << {idx_q[3:0], 2'b00});
  end

  always_comb begin
    core_we   = 1'b0;
    core_addr = '0;
    core_data = '0;
    if (state_q == S_RUN9 && emit9) begin
      core_we   = 1'b1;
      core_addr = base_dst + {2'b00, wr_q};
      core_data = {6'b0, buf_q[39:30], 6'b0, buf_q[29:20],
                   6'b0, buf_q[19:10], 6'b0, buf_q[9:0]};
    end else if (state_q == S_RUN11 && idx_q[3:0] == 4'hF) begin
      core_we   = 1'b1;
      core_addr = base_dst + {8'd0, idx_q[5:4]};
      core_data = acc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (ext_ok && wea_ext) mem[{1'b0, address_ext}] <= dina_ext;
    else if (core_we)      mem[core_addr] <= core_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) douta_ext <= '0;
    else        douta_ext <= mem[{1'b0, address_ext}];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_dst <= '0; base_a <= '0; base_b <= '0; fin9_q <= 1'b0;
      buf_q <= '0; bits_q <= '0; ld_q <= '0; wr_q <= '0;
      idx_q <= '0; acc_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          base_dst <= cmd_q[34:25];
          base_a   <= cmd_q[24:15];
          base_b   <= cmd_q[14:5];
          fin9_q   <= (opcode == 5'd9);
          buf_q <= '0; bits_q <= '0; ld_q <= '0; wr_q <= '0;
          idx_q <= '0; acc_q <= '0;
        end
        // Either drain one 40-bit output word or append one 64-bit source word.
        S_RUN9: begin
          if (emit9) begin
            buf_q  <= buf_q >> 40;
            bits_q <= bits_q - 7'd40;
            wr_q   <= wr_q + 8'd1;
          end else begin
            buf_q  <= buf_q | ({40'd0, rd_a} << bits_q);
            bits_q <= bits_q + 7'd64;
            ld_q   <= ld_q + 7'd1;
          end
        end
        S_RUN11: begin
          acc_q <= acc_nxt;
          idx_q <= idx_q + 6'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_compute_core3.sv
// Directed bench for compute_core3: reset, op 9, op 11, done release,
// busy-write rejection and unsupported commands.
module tb_compute_core3;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [8:0]  address_ext = '0;
  logic [63:0] dina_ext = '0;
  logic        wea_ext = 1'b0;
  logic [63:0] douta_ext;
  logic [34:0] command_in = '0;
  logic        command_we0 = 1'b0;
  logic        command_we1 = 1'b0;
  logic        done_shake, done_vmul, done_addround, done_addpack;
  logic        done_bs2polvecp, done_unpack;

  int n_chk = 0;
  int n_fail = 0;

  logic [63:0] ct [120];
  logic [63:0] sc [16];
  logic [63:0] vw [64];

  compute_core3 dut (
    .clk(clk), .rst_n(rst_n),
    .address_ext(address_ext), .dina_ext(dina_ext), .wea_ext(wea_ext),
    .douta_ext(douta_ext),
    .command_in(command_in), .command_we0(command_we0), .command_we1(command_we1),
    .done_shake(done_shake), .done_vmul(done_vmul), .done_addround(done_addround),
    .done_addpack(done_addpack), .done_bs2polvecp(done_bs2polvecp),
    .done_unpack(done_unpack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ext_wr(input logic [8:0] a, input logic [63:0] d);
    @(negedge clk);
    address_ext = a; dina_ext = d; wea_ext = 1'b1;
    @(negedge clk);
    wea_ext = 1'b0;
  endtask

  task automatic ext_rd(input logic [8:0] a, output logic [63:0] d);
    @(negedge clk);
    address_ext = a;
    @(negedge clk);
    d = douta_ext;
  endtask

  task automatic issue(input logic [9:0] dst, input logic [9:0] a,
                       input logic [9:0] b, input logic [4:0] op);
    @(negedge clk);
    command_in = {dst, a, b, op}; command_we0 = 1'b1;
    @(negedge clk);
    command_we0 = 1'b0;
  endtask

  task automatic wait_done(input bit is9, output int cyc);
    cyc = 0;
    while (((is9 ? done_bs2polvecp : done_unpack) !== 1'b1) && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  function automatic logic [63:0] exp9(int w);
    logic [63:0] r;
    int p;
    r = '0;
    for (int k = 0; k < 4; k++)
      for (int b = 0; b < 10; b++) begin
        p = 10 * (4 * w + k) + b;
        r[16 * k + b] = ct[p / 64][p % 64];
      end
    return r;
  endfunction

  function automatic logic [63:0] exp11(int w);
    logic [63:0] r;
    logic [3:0]  op;
    logic [15:0] lane;
    int i, val;
    r = '0;
    for (int b = 0; b < 64; b++) begin
      i    = 64 * w + b;
      op   = sc[i / 16][(i % 16) * 4 +: 4];
      lane = vw[i / 4][(i % 4) * 16 +: 16];
      val  = int'(lane[9:0]) + 228 - int'(op) * 64;
      val  = ((val % 1024) + 1024) % 1024;
      r[b] = (val >= 512);
    end
    return r;
  endfunction

  initial begin
    int cyc;
    logic [63:0] d;

    ct[0] = 64'h0b00084be7d17c3d;
    for (int i = 1; i < 120; i++) ct[i] = {$urandom, $urandom};
    sc[0] = 64'hd79c6171fff9ec60;
    for (int i = 1; i < 16; i++) sc[i] = {$urandom, $urandom};
    vw[0] = 64'h01a001e30105021a;
    for (int i = 1; i < 64; i++) vw[i] = {$urandom, $urandom};

    repeat (3) @(negedge clk);
    chk("rst_douta", douta_ext, 64'd0);
    chk("rst_done", {58'd0, done_shake, done_vmul, done_addround, done_addpack,
                     done_bs2polvecp, done_unpack}, 64'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_done", {58'd0, done_shake, done_vmul, done_addround, done_addpack,
                          done_bs2polvecp, done_unpack}, 64'd0);
    chk("post_rst_idle", 64'(dut.state_q), 64'd0);

    for (int i = 0; i < 120; i++) ext_wr(9'(i), ct[i]);
    ext_rd(9'd0, d);
    chk("ext_readback", d, ct[0]);

    issue(10'd512, 10'd0, 10'd0, 5'd9);
    wait_done(1'b1, cyc);
    chk("op9_latency", 64'(cyc <= 400), 64'd1);
    chk("op9_done", 64'(done_bs2polvecp), 64'd1);
    chk("op9_word0", dut.mem[512], 64'h012f_027d_005f_003d);
    for (int w = 0; w < 192; w++) chk("op9_word", dut.mem[512 + w], exp9(w));

    issue(10'd0, 10'd0, 10'd0, 5'd0);
    chk("done_hold", 64'(done_bs2polvecp), 64'd1);
    @(negedge clk);
    chk("done_release", 64'(done_bs2polvecp), 64'd0);
    chk("release_idle", 64'(dut.state_q), 64'd0);

    issue(10'd600, 10'd0, 10'd0, 5'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); command_we1 = 1'b1;
      @(negedge clk); command_we1 = 1'b0;
    end
    repeat (20) @(negedge clk);
    chk("unsup_done", {58'd0, done_shake, done_vmul, done_addround, done_addpack,
                       done_bs2polvecp, done_unpack}, 64'd0);
    chk("unsup_idle", 64'(dut.state_q), 64'd0);
    issue(10'd0, 10'd0, 10'd0, 5'd0);

    issue(10'd256, 10'd0, 10'd0, 5'd9);
    repeat (10) @(negedge clk);
    address_ext = 9'd5; dina_ext = ~ct[5]; wea_ext = 1'b1;
    @(negedge clk);
    wea_ext = 1'b0;
    wait_done(1'b1, cyc);
    chk("busy_done", 64'(done_bs2polvecp), 64'd1);
    issue(10'd0, 10'd0, 10'd0, 5'd0);
    ext_rd(9'd5, d);
    chk("busy_write_ignored", d, ct[5]);
    for (int w = 0; w < 192; w++) begin
      ext_rd(9'(256 + w), d);
      chk("busy_op9_word", d, exp9(w));
    end

    for (int i = 0; i < 16; i++) ext_wr(9'(i), sc[i]);
    for (int i = 0; i < 64; i++) ext_wr(9'(16 + i), vw[i]);
    issue(10'd512, 10'd0, 10'd16, 5'd11);
    wait_done(1'b0, cyc);
    chk("op11_latency", 64'(cyc <= 200), 64'd1);
    chk("op11_done", 64'(done_unpack), 64'd1);
    chk("op11_no_bs2", 64'(done_bs2polvecp), 64'd0);
    chk("op11_low_nibble", 64'(dut.mem[512][3:0]), 64'hd);
    for (int w = 0; w < 4; w++) chk("op11_word", dut.mem[512 + w], exp11(w));
    issue(10'd0, 10'd0, 10'd0, 5'd0);
    @(negedge clk);
    chk("op11_release", 64'(done_unpack), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
